// File: rtl/audio_voice_sequencer_if.sv
// Signal bundle between the voice sequencer, its sample timer, the attribute RAM
// read port and the downstream waveform generator.
interface audio_voice_sequencer_if #(
    parameter int ADDR_W  = 5,
    parameter int PHASE_W = 17
);
    logic                enable_i;
    logic                sample_tick_i;
    logic                clr_overrun_i;
    logic [ADDR_W-1:0]   attr_rd_addr_o;
    logic                attr_rd_en_o;
    logic [31:0]         attr_rd_data_i;
    logic                voice_valid_o;
    logic [ADDR_W-1:0]   voice_idx_o;
    logic [PHASE_W-1:0]  voice_phase_o;
    logic [31:0]         voice_attr_o;
    logic                frame_done_o;
    logic                busy_o;
    logic                overrun_o;

    modport master (
        input  enable_i,
        input  sample_tick_i,
        input  clr_overrun_i,
        input  attr_rd_data_i,
        output attr_rd_addr_o,
        output attr_rd_en_o,
        output voice_valid_o,
        output voice_idx_o,
        output voice_phase_o,
        output voice_attr_o,
        output frame_done_o,
        output busy_o,
        output overrun_o
    );

    modport slave (
        output enable_i,
        output sample_tick_i,
        output clr_overrun_i,
        output attr_rd_data_i,
        input  attr_rd_addr_o,
        input  attr_rd_en_o,
        input  voice_valid_o,
        input  voice_idx_o,
        input  voice_phase_o,
        input  voice_attr_o,
        input  frame_done_o,
        input  busy_o,
        input  overrun_o
    );
endinterface

// File: rtl/audio_voice_sequencer.sv
// Per-sample voice scheduler: walks every voice, fetches its attribute word,
// advances its phase accumulator and strobes the result to the waveform generator.
module audio_voice_sequencer #(
    parameter int NUM_VOICES = 16,
    parameter int ADDR_W     = 5,
    parameter int PHASE_W    = 17
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    audio_voice_sequencer_if.master bus
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [ADDR_W-1:0] LAST_VOICE = ADDR_W'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   counter;
    logic [PHASE_W-1:0]  phase_mem [NUM_VOICES];
    logic [IDX_W-1:0]    voice_sel;
    logic [PHASE_W-1:0]  next_phase;

    always_comb begin
        voice_sel  = counter[IDX_W-1:0];
        next_phase = phase_mem[voice_sel] + PHASE_W'(bus.attr_rd_data_i[15:0]);
    end

    // Outputs are registered alongside the state so each strobe lines up with its state's exit edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state              <= S_IDLE;
            counter            <= '0;
            bus.attr_rd_addr_o <= '0;
            bus.attr_rd_en_o   <= 1'b0;
            bus.voice_valid_o  <= 1'b0;
            bus.voice_idx_o    <= '0;
            bus.voice_phase_o  <= '0;
            bus.voice_attr_o   <= '0;
            bus.frame_done_o   <= 1'b0;
            bus.busy_o         <= 1'b0;
            bus.overrun_o      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_mem[i] <= '0;
            end
        end else begin
            bus.attr_rd_en_o  <= 1'b0;
            bus.voice_valid_o <= 1'b0;
            bus.frame_done_o  <= 1'b0;

            if (bus.sample_tick_i && (state != S_IDLE)) begin
                bus.overrun_o <= 1'b1;
            end else if (bus.clr_overrun_i) begin
                bus.overrun_o <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.sample_tick_i && bus.enable_i) begin
                        counter            <= '0;
                        bus.attr_rd_addr_o <= '0;
                        bus.attr_rd_en_o   <= 1'b1;
                        bus.busy_o         <= 1'b1;
                        state              <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    phase_mem[voice_sel] <= next_phase;
                    bus.voice_valid_o    <= 1'b1;
                    bus.voice_idx_o      <= counter;
                    bus.voice_phase_o    <= next_phase;
                    bus.voice_attr_o     <= bus.attr_rd_data_i;
                    if (counter == LAST_VOICE) begin
                        bus.frame_done_o <= 1'b1;
                        state            <= S_DONE;
                    end else begin
                        counter            <= counter + 1'b1;
                        bus.attr_rd_addr_o <= counter + 1'b1;
                        bus.attr_rd_en_o   <= 1'b1;
                        state              <= S_FETCH;
                    end
                end
                S_DONE: begin
                    bus.busy_o <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    bus.busy_o <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
